// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite pipeline: object-table field layout,
// sprite dimensions and the line-sequencer state encoding.
package sprite_pkg;

  localparam int OBJ_VALID_BIT = 23;
  localparam int OBJ_TILE_MSB  = 22;
  localparam int OBJ_TILE_LSB  = 19;
  localparam int OBJ_X_MSB     = 18;
  localparam int OBJ_X_LSB     = 9;
  localparam int OBJ_Y_MSB     = 8;
  localparam int OBJ_Y_LSB     = 0;

  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    TEST    = 3'd2,
    ISSUE   = 3'd3,
    RELEASE = 3'd4,
    NEXT    = 3'd5
  } state_t;

endpackage

// File: rtl/sprite_line_hit.sv
// Vertical coverage test: does a valid object starting at obj_y cover line_y?
// Unsigned 10-bit compare; a line above the object produces a borrow and is
// treated as a miss rather than wrapping into range.
module sprite_line_hit #(
  parameter int SPRITE_H = 32
) (
  input  logic [9:0] line_y,
  input  logic [8:0] obj_y,
  input  logic       obj_valid,
  output logic       hit
);

  logic [9:0] y_ext;
  logic [9:0] diff;

  assign y_ext = {1'b0, obj_y};
  assign diff  = line_y - y_ext;
  assign hit   = obj_valid && (line_y >= y_ext) && ({1'b0, diff} < 11'(SPRITE_H));

endmodule

// File: rtl/sprite_line_sequencer.sv
// Per-scanline object walk: finds every valid object covering the line and
// hands each to the sprite-drawing worker over a start/ready handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for line_req
// FETCH   | obj_addr = idx presented to the object table
// TEST    | obj_data valid; vertical hit test, capture entry on hit
// ISSUE   | start high until the worker returns ready
// RELEASE | start low; wait for ready to drop so it cannot be reused
// NEXT    | advance idx or finish the line
module sprite_line_sequencer #(
  parameter int NUM_OBJ  = 16,
  parameter int SPRITE_H = 32
) (
  input  logic                         clk50,
  input  logic                         reset,
  input  logic                         line_req,
  input  logic [9:0]                   line_y,
  output logic [$clog2(NUM_OBJ)-1:0]   obj_addr,
  input  logic [23:0]                  obj_data,
  output logic [23:0]                  object_info,
  output logic [9:0]                   ycoor,
  output logic                         start,
  input  logic                         ready,
  output logic                         busy,
  output logic                         line_done,
  output logic [$clog2(NUM_OBJ+1)-1:0] hit_count,
  output logic                         overrun
);

  import sprite_pkg::*;

  localparam int IW = $clog2(NUM_OBJ);
  localparam int HW = $clog2(NUM_OBJ + 1);

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic          hit;
  logic          last_obj;

  assign obj_addr = idx;
  assign last_obj = (idx == IW'(NUM_OBJ - 1));

  sprite_line_hit #(.SPRITE_H(SPRITE_H)) u_hit (
    .line_y    (ycoor),
    .obj_y     (obj_data[OBJ_Y_MSB:OBJ_Y_LSB]),
    .obj_valid (obj_data[OBJ_VALID_BIT]),
    .hit       (hit)
  );

  // State register.
  always_ff @(posedge clk50) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_req) state_nxt = FETCH;
      FETCH:   state_nxt = TEST;
      TEST:    state_nxt = hit ? ISSUE : NEXT;
      ISSUE:   if (ready) state_nxt = RELEASE;
      RELEASE: if (!ready) state_nxt = NEXT;
      NEXT:    state_nxt = last_obj ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and walk datapath; start never depends combinationally on ready.
  always_ff @(posedge clk50) begin
    if (!reset) begin
      idx         <= '0;
      ycoor       <= '0;
      object_info <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      line_done   <= 1'b0;
      hit_count   <= '0;
      overrun     <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if (line_req && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (line_req) begin
            ycoor     <= line_y;
            idx       <= '0;
            hit_count <= '0;
            busy      <= 1'b1;
          end
        end
        TEST: begin
          if (hit) begin
            object_info <= obj_data;
            start       <= 1'b1;
          end
        end
        ISSUE: begin
          if (ready) begin
            start     <= 1'b0;
            hit_count <= hit_count + HW'(1);
          end
        end
        NEXT: begin
          if (last_obj) begin
            line_done <= 1'b1;
            busy      <= 1'b0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_sequencer.sv
// Scoreboard bench for sprite_line_sequencer: expected issues and line results
// are queued when a line is launched; a negedge monitor pops them as the DUT
// raises start or line_done.
module tb_sprite_line_sequencer;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        line_req;
  logic [9:0]  line_y;
  logic [3:0]  obj_addr;
  logic [23:0] obj_data;
  logic [23:0] object_info;
  logic [9:0]  ycoor;
  logic        start;
  logic        ready;
  logic        busy;
  logic        line_done;
  logic [4:0]  hit_count;
  logic        overrun;

  sprite_line_sequencer #(.NUM_OBJ(16), .SPRITE_H(32)) dut (
    .clk50       (clk50),
    .reset       (reset),
    .line_req    (line_req),
    .line_y      (line_y),
    .obj_addr    (obj_addr),
    .obj_data    (obj_data),
    .object_info (object_info),
    .ycoor       (ycoor),
    .start       (start),
    .ready       (ready),
    .busy        (busy),
    .line_done   (line_done),
    .hit_count   (hit_count),
    .overrun     (overrun)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    logic [23:0] info;
    logic [9:0]  y;
  } exp_t;

  exp_t        issue_q[$];
  int          done_q[$];
  logic [23:0] tbl[16];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ready_delay = 1;
  int          last_latency = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] mk(input bit v, input int tile, input int x, input int y);
    return {v, 4'(tile), 10'(x), 9'(y)};
  endfunction

  // Synchronous object table: address seen in one cycle, data valid the next.
  initial begin
    logic [3:0] a;
    a = '0;
    obj_data = '0;
    forever begin
      @(negedge clk50);
      a = obj_addr;
      @(posedge clk50);
      #1 obj_data = tbl[a];
    end
  end

  // Worker model: one-cycle ready pulse ready_delay cycles after start rises.
  initial begin
    int cnt;
    cnt = 0;
    ready = 1'b0;
    forever begin
      @(negedge clk50);
      if (start && !ready) begin
        cnt++;
        if (cnt >= ready_delay) begin
          ready = 1'b1;
          cnt = 0;
        end
      end else begin
        ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: pops expectations when start rises or line_done pulses.
  initial begin
    logic        start_prev;
    logic [23:0] held;
    int          low_cnt;
    bit          seen_start;
    exp_t        e;
    start_prev = 1'b0;
    held = '0;
    low_cnt = 0;
    seen_start = 1'b0;
    forever begin
      @(negedge clk50);
      if (start && !start_prev) begin
        if (seen_start) check("start_gap", 32'(low_cnt >= 1), 32'd1);
        seen_start = 1'b1;
        if (issue_q.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
        end else begin
          e = issue_q.pop_front();
          check("object_info", 32'(object_info), 32'(e.info));
          check("ycoor", 32'(ycoor), 32'(e.y));
        end
        held = object_info;
      end else if (start && start_prev) begin
        check("object_info_stable", 32'(object_info), 32'(held));
      end
      if (start) low_cnt = 0;
      else       low_cnt++;
      if (line_done) begin
        check("busy_at_done", 32'(busy), 32'd0);
        if (done_q.size() == 0) begin
          check("unexpected_line_done", 32'd1, 32'd0);
        end else begin
          check("hit_count", 32'(hit_count), 32'(done_q.pop_front()));
        end
        seen_start = 1'b0;
      end
      start_prev = start;
    end
  end

  task automatic clear_tbl();
    for (int i = 0; i < 16; i++) tbl[i] = '0;
  endtask

  // Pulse line_req and wait (bounded) for line_done; optionally pulse a second
  // line_req in cycle req_again counted from the accepted one.
  task automatic launch_line(input logic [9:0] y, input int req_again);
    int n;
    bit done;
    @(negedge clk50);
    line_y   = y;
    line_req = 1'b1;
    @(negedge clk50);
    line_req = 1'b0;
    line_y   = 10'h3FF;
    n = 1;
    done = line_done;
    while (!done && n < 5000) begin
      if (n == req_again) begin
        line_req = 1'b1;
        line_y   = 10'd0;
      end else begin
        line_req = 1'b0;
      end
      @(negedge clk50);
      n++;
      if (line_done) done = 1'b1;
    end
    line_req = 1'b0;
    last_latency = n;
    if (!done) check("line_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    line_req = 1'b0;
    line_y   = '0;
    clear_tbl();
    tbl[0] = mk(1, 1, 0, 0);

    // Reset, then idle with no line_req.
    repeat (2) @(posedge clk50);
    #1;
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_obj_addr", 32'(obj_addr), 32'd0);
    check("rst_object_info", 32'(object_info), 32'd0);
    check("rst_ycoor", 32'(ycoor), 32'd0);
    @(negedge clk50);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk50);
      check("idle_start", 32'(start), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_line_done", 32'(line_done), 32'd0);
    end

    // Empty table: pure walk latency.
    clear_tbl();
    done_q.push_back(0);
    launch_line(10'd5, 0);
    check("empty_latency", 32'(last_latency), 32'd49);

    // Single hit.
    ready_delay = 3;
    tbl[3] = mk(1, 2, 40, 100);
    issue_q.push_back('{tbl[3], 10'd110});
    done_q.push_back(1);
    launch_line(10'd110, 0);

    // Vertical boundaries around y=100.
    done_q.push_back(0);
    launch_line(10'd99, 0);
    issue_q.push_back('{tbl[3], 10'd100});
    done_q.push_back(1);
    launch_line(10'd100, 0);
    issue_q.push_back('{tbl[3], 10'd131});
    done_q.push_back(1);
    launch_line(10'd131, 0);
    done_q.push_back(0);
    launch_line(10'd132, 0);
    tbl[3] = mk(0, 2, 40, 100);
    done_q.push_back(0);
    launch_line(10'd100, 0);

    // Multiple hits in index order with a slow worker.
    clear_tbl();
    ready_delay = 34;
    tbl[0]  = mk(1, 1, 0, 200);
    tbl[5]  = mk(1, 5, 100, 190);
    tbl[7]  = mk(1, 7, 50, 300);
    tbl[15] = mk(1, 15, 300, 210);
    issue_q.push_back('{tbl[0], 10'd215});
    issue_q.push_back('{tbl[5], 10'd215});
    issue_q.push_back('{tbl[15], 10'd215});
    done_q.push_back(3);
    launch_line(10'd215, 0);

    // Overrun: second line_req while busy is ignored; flag is sticky.
    clear_tbl();
    ready_delay = 2;
    tbl[3] = mk(1, 2, 40, 100);
    check("overrun_before", 32'(overrun), 32'd0);
    issue_q.push_back('{tbl[3], 10'd110});
    done_q.push_back(1);
    launch_line(10'd110, 5);
    check("overrun_set", 32'(overrun), 32'd1);
    issue_q.push_back('{tbl[3], 10'd105});
    done_q.push_back(1);
    launch_line(10'd105, 0);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset while start is high.
    ready_delay = 1000;
    issue_q.push_back('{tbl[3], 10'd110});
    @(negedge clk50);
    line_y   = 10'd110;
    line_req = 1'b1;
    @(negedge clk50);
    line_req = 1'b0;
    n = 0;
    while (!start && n < 100) begin
      @(negedge clk50);
      n++;
    end
    check("start_before_reset", 32'(start), 32'd1);
    reset = 1'b0;
    @(posedge clk50);
    #1;
    check("reset_mid_start", 32'(start), 32'd0);
    check("reset_mid_busy", 32'(busy), 32'd0);
    check("reset_mid_overrun", 32'(overrun), 32'd0);
    @(negedge clk50);
    reset = 1'b1;
    check("reset_mid_obj_addr", 32'(obj_addr), 32'd0);
    check("reset_mid_hit_count", 32'(hit_count), 32'd0);
    ready_delay = 2;
    tbl[0] = mk(1, 3, 8, 100);
    issue_q.push_back('{tbl[0], 10'd110});
    issue_q.push_back('{tbl[3], 10'd110});
    done_q.push_back(2);
    launch_line(10'd110, 0);

    repeat (3) @(negedge clk50);
    check("issue_q_drained", 32'(issue_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_line_sequencer.md
# sprite_line_sequencer

Initiator side of the single-sprite draw handshake. For each scanline it walks the object table, selects every valid object that vertically covers the current line, and hands each one in turn to the single-sprite drawing worker. The hand-off uses start/ready. The block sits between the VGA line-timing logic, which pulses the line request, and the sprite-drawing worker, which emits pixel addresses.

## Interface
Parameters:
- NUM_OBJ, 16: object table entries; table addresses are 0..NUM_OBJ-1.
- SPRITE_H, 32: sprite height in lines.

Ports:
- clk50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low; sampled on clk50, asserted when 0.
- line_req  in  1  one-cycle pulse: begin processing scanline line_y.
- line_y  in  10  scanline number; sampled only on an accepted line_req.
- obj_addr  out  $clog2(NUM_OBJ)  object table read address.
- obj_data  in  24  object entry, valid 1 cycle after obj_addr. Field layout:
  - [23] valid
  - [22:19] tile id
  - [18:9] x
  - [8:0] y
- object_info  out  24  entry handed to the worker; held stable while start=1.
- ycoor  out  10  latched line_y, driven to the worker.
- start  out  1  request to the worker.
- ready  in  1  worker completion.
- busy  out  1  high from accepted line_req until line_done.
- line_done  out  1  one-cycle pulse when the table walk ends.
- hit_count  out  $clog2(NUM_OBJ+1)  sprites issued on the last line; valid from line_done until the next accepted line_req.
- overrun  out  1  sticky; set when line_req arrives while busy.

## Operation
- States: IDLE, FETCH, TEST, ISSUE, RELEASE, NEXT.
- IDLE:
  - On line_req: latch line_y into ycoor, set idx=0, clear hit_count, set busy, go to FETCH.
- FETCH: drive obj_addr=idx; go to TEST.
- TEST: obj_data is valid this cycle.
  - Hit = obj_data[23] AND line_y_latched >= y AND (line_y_latched - y) < SPRITE_H.
  - Compare in 10-bit unsigned, with y zero-extended.
  - On hit: register obj_data into object_info, go to ISSUE. Otherwise go to NEXT.
- ISSUE: start=1.
  - Stay until ready=1.
  - On ready: start=0 next cycle, hit_count+1, go to RELEASE.
- RELEASE: start=0; wait for ready=0, then go to NEXT.
  - This prevents a stale ready from completing the next object.
- NEXT:
  - If idx==NUM_OBJ-1: pulse line_done, clear busy, go to IDLE.
  - Else idx+1, go to FETCH.
- line_req while busy: ignored, and overrun set. overrun is cleared only by reset.
- object_info and ycoor are unchanged outside the TEST hit and line-accept events.

## Timing
- Reset values:
  - outputs: start=0, busy=0, line_done=0, hit_count=0, overrun=0, obj_addr=0, object_info=0, ycoor=0.
  - state: IDLE.
- Reset mid-line: start drops on the next edge with no wait for ready. The worker must be reset by the same signal.
- line_req accepted at edge N → FETCH in cycle N+1, first TEST in N+2.
- Missed object costs 3 cycles: FETCH, TEST, NEXT.
- Hit costs 3 cycles plus worker turnaround plus 1 RELEASE cycle (minimum, with ready low the cycle after start falls).
- Empty or all-miss table: line_done = 3·NUM_OBJ + 1 cycles after line_req (49 for 16).
- line_done and the final state change to IDLE occur in the same cycle. A line_req in the cycle after line_done is accepted.
- Boundary hits for y=100, SPRITE_H=32:
  - line_y=131 hits; line_y=132 misses.
  - line_y=99 misses (no wrap: the borrow forces a miss).
- All outputs are registered; start has no combinational path from ready.

## Structure
- Shared package sprite_pkg holds:
  - object field constants: OBJ_VALID_BIT=23, OBJ_TILE_MSB/LSB=22/19, OBJ_X_MSB/LSB=18/9, OBJ_Y_MSB/LSB=8/0
  - SPRITE_W=32, SPRITE_H=32
  - the state enum typedef
- Optional sub-module sprite_line_hit: the combinational vertical hit test, reusable by collision logic.

## Test plan
- Reset then idle: table with one valid object y=0. Hold reset low 2 cycles, no line_req → start, busy, line_done stay 0.
- Single hit: entry 3 = {valid, tile 2, x=40, y=100}, line_y=110 → exactly one start. object_info = entry 3 while start=1. hit_count=1 at line_done.
- Boundaries: y=100 with line_y 99/100/131/132 → hits 0/1/1/0. Invalid entry with y=100, line_y=100 → no start.
- Multiple and order: entries 0, 5, 15 hit, with the worker model's ready delayed 34 cycles → starts in index order 0, 5, 15. start low at least 1 cycle between them; hit_count=3.
- Overrun: line_req at cycle 5 while busy → ignored, overrun=1 and sticky; next line result unchanged.
- Reset mid-ISSUE: reset low while start=1 → start=0 next edge, busy=0. A new line_req then walks from index 0.
